// File: rtl/regfile_pkg.sv
// Shared widths, the x0 constant and the operand entry carried from S1 into the
// output buffer of the regfile operand fetch block.
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int AW    = 4;
  localparam int TAGW  = 4;
  localparam int NREGS = 2 ** AW;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [TAGW-1:0] tag;
  } operand_entry_t;

  // A write that lands in a real register (x0 writes are ignored) at address ra.
  function automatic logic reg_hit(input logic          wv,
                                   input logic [AW-1:0] wa,
                                   input logic [AW-1:0] ra);
    return wv && (wa == ra) && (wa != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_operand_fetch_fifo.sv
// Two-entry operand FIFO whose stored source data is refreshed by every live
// writeback whose address matches, so the head entry never presents stale data.
module operand_skid_fifo
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  operand_entry_t  push_entry,
  input  logic            pop,
  input  logic            snoop_valid,
  input  logic [AW-1:0]   snoop_addr,
  input  logic [XLEN-1:0] snoop_data,
  output operand_entry_t  head_entry,
  output logic [1:0]      count
);

  operand_entry_t mem [2];
  logic           wr_ptr;
  logic           rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // Snooping free slots is harmless: a push rewrites the whole entry.
      for (int i = 0; i < 2; i++) begin
        if (push && (wr_ptr == 1'(i))) begin
          mem[i] <= push_entry;
        end else if (snoop_valid) begin
          if (mem[i].rs1_addr == snoop_addr) mem[i].rs1_data <= snoop_data;
          if (mem[i].rs2_addr == snoop_addr) mem[i].rs2_data <= snoop_data;
        end
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_entry = mem[rd_ptr];

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch front end: issues regfile reads, resolves operands against
// writebacks one cycle later, and buffers complete pairs for execute.
module regfile_operand_fetch
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  // Handshakes (req_*, op_*): a transfer happens in every cycle where valid
  // and ready are both high; valid never depends on ready.
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_rs1,
  input  logic [AW-1:0]   req_rs2,
  input  logic [TAGW-1:0] req_tag,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            rs1_read,
  output logic [AW-1:0]   rs1_addr,
  input  logic [XLEN-1:0] rs1_rdata,
  output logic            rs2_read,
  output logic [AW-1:0]   rs2_addr,
  input  logic [XLEN-1:0] rs2_rdata,
  output logic            rd_write,
  output logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_wdata,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [XLEN-1:0] op_rs1_data,
  output logic [XLEN-1:0] op_rs2_data,
  output logic [TAGW-1:0] op_tag
);

  logic            accept;
  logic            pop;
  logic            wb_live;
  logic [2:0]      occupancy;
  logic [1:0]      count;

  logic            s1_valid;
  logic [AW-1:0]   s1_rs1;
  logic [AW-1:0]   s1_rs2;
  logic [TAGW-1:0] s1_tag;
  logic            s1_byp1;
  logic            s1_byp2;
  logic [XLEN-1:0] s1_byp1_data;
  logic [XLEN-1:0] s1_byp2_data;

  operand_entry_t  s1_entry;
  operand_entry_t  head_entry;

  assign wb_live  = wb_valid && (wb_addr != REG_ZERO);
  assign rd_write = wb_live;
  assign rd_addr  = wb_addr;
  assign rd_wdata = wb_data;

  // S1 always drains into the buffer, so it counts against buffer space.
  assign pop       = op_valid && op_ready;
  assign occupancy = 3'(s1_valid) + 3'(count) - 3'(pop);
  assign req_ready = rst_n && (occupancy < 3'd2);
  assign accept    = req_valid && req_ready;

  // The S1 address registers double as the held read addresses when idle.
  assign rs1_read = accept && (req_rs1 != REG_ZERO);
  assign rs2_read = accept && (req_rs2 != REG_ZERO);
  assign rs1_addr = accept ? req_rs1 : s1_rs1;
  assign rs2_addr = accept ? req_rs2 : s1_rs2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_rs1       <= '0;
      s1_rs2       <= '0;
      s1_tag       <= '0;
      s1_byp1      <= 1'b0;
      s1_byp2      <= 1'b0;
      s1_byp1_data <= '0;
      s1_byp2_data <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_rs1       <= req_rs1;
        s1_rs2       <= req_rs2;
        s1_tag       <= req_tag;
        s1_byp1      <= reg_hit(wb_valid, wb_addr, req_rs1);
        s1_byp2      <= reg_hit(wb_valid, wb_addr, req_rs2);
        s1_byp1_data <= wb_data;
        s1_byp2_data <= wb_data;
      end
    end
  end

  // Newest value wins: S1-cycle writeback, then issue-cycle writeback, then regfile.
  always_comb begin
    s1_entry          = '0;
    s1_entry.rs1_addr = s1_rs1;
    s1_entry.rs2_addr = s1_rs2;
    s1_entry.tag      = s1_tag;
    if (s1_rs1 == REG_ZERO)                   s1_entry.rs1_data = '0;
    else if (reg_hit(wb_valid, wb_addr, s1_rs1)) s1_entry.rs1_data = wb_data;
    else if (s1_byp1)                         s1_entry.rs1_data = s1_byp1_data;
    else                                      s1_entry.rs1_data = rs1_rdata;
    if (s1_rs2 == REG_ZERO)                   s1_entry.rs2_data = '0;
    else if (reg_hit(wb_valid, wb_addr, s1_rs2)) s1_entry.rs2_data = wb_data;
    else if (s1_byp2)                         s1_entry.rs2_data = s1_byp2_data;
    else                                      s1_entry.rs2_data = rs2_rdata;
  end

  operand_skid_fifo u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (s1_valid),
    .push_entry  (s1_entry),
    .pop         (pop),
    .snoop_valid (wb_live),
    .snoop_addr  (wb_addr),
    .snoop_data  (wb_data),
    .head_entry  (head_entry),
    .count       (count)
  );

  assign op_valid    = (count != 2'd0);
  assign op_rs1_data = head_entry.rs1_data;
  assign op_rs2_data = head_entry.rs2_data;
  assign op_tag      = head_entry.tag;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed bench for regfile_operand_fetch with a behavioural 2R/1W regfile
// (read data one cycle after the read, pre-write value on same-cycle collision).
module tb_regfile_operand_fetch;
  import regfile_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_rs1;
  logic [AW-1:0]   req_rs2;
  logic [TAGW-1:0] req_tag;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            rs1_read;
  logic [AW-1:0]   rs1_addr;
  logic [XLEN-1:0] rs1_rdata;
  logic            rs2_read;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs2_rdata;
  logic            rd_write;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_wdata;
  logic            op_valid;
  logic            op_ready;
  logic [XLEN-1:0] op_rs1_data;
  logic [XLEN-1:0] op_rs2_data;
  logic [TAGW-1:0] op_tag;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [TAGW+XLEN-1:0] exp_q [$];
  logic [TAGW+XLEN-1:0] exp_item;
  logic [XLEN-1:0]      rf [NREGS];

  regfile_operand_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_tag     (req_tag),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .rs1_read    (rs1_read),
    .rs1_addr    (rs1_addr),
    .rs1_rdata   (rs1_rdata),
    .rs2_read    (rs2_read),
    .rs2_addr    (rs2_addr),
    .rs2_rdata   (rs2_rdata),
    .rd_write    (rd_write),
    .rd_addr     (rd_addr),
    .rd_wdata    (rd_wdata),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_rs1_data (op_rs1_data),
    .op_rs2_data (op_rs2_data),
    .op_tag      (op_tag)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural regfile; garbage outside the valid read cycle exposes misuse.
  initial for (int i = 0; i < NREGS; i++) rf[i] = '0;
  always @(posedge clk) begin
    rs1_rdata <= rs1_read ? rf[rs1_addr] : 32'hDEAD_0001;
    rs2_rdata <= rs2_read ? rf[rs2_addr] : 32'hDEAD_0002;
    if (rd_write) rf[rd_addr] <= rd_wdata;
  end

  task automatic check(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                           input logic [TAGW-1:0] t);
    req_valid = 1'b1;
    req_rs1   = a1;
    req_rs2   = a2;
    req_tag   = t;
  endtask

  task automatic drive_wb(input logic v, input logic [AW-1:0] a,
                          input logic [XLEN-1:0] d);
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    drive_wb(1'b0, '0, '0);
    op_ready = 1'b0;

    // Reset state
    cyc(); cyc(); #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_op_rs1", op_rs1_data, 32'd0);
    check("rst_op_rs2", op_rs2_data, 32'd0);
    check("rst_op_tag", 32'(op_tag), 32'd0);

    // T1: write x3, then read it back with rs2=x0
    cyc(); rst_n = 1'b1; op_ready = 1'b1;
    drive_wb(1'b1, 4'd3, 32'hA5A5_0001); #1;
    check("t1_rd_write", 32'(rd_write), 32'd1);
    check("t1_rd_addr", 32'(rd_addr), 32'd3);
    check("t1_rd_wdata", rd_wdata, 32'hA5A5_0001);
    cyc(); drive_wb(1'b0, '0, '0); drive_req(4'd3, 4'd0, 4'd1); #1;
    check("t1_req_ready", 32'(req_ready), 32'd1);
    check("t1_rs1_read", 32'(rs1_read), 32'd1);
    check("t1_rs2_read", 32'(rs2_read), 32'd0);
    check("t1_rs1_addr", 32'(rs1_addr), 32'd3);
    cyc(); req_valid = 1'b0; #1;
    check("t1_lat1_op_valid", 32'(op_valid), 32'd0);
    check("t1_idle_rs1_read", 32'(rs1_read), 32'd0);
    check("t1_hold_rs1_addr", 32'(rs1_addr), 32'd3);
    cyc(); #1;
    check("t1_op_valid", 32'(op_valid), 32'd1);
    check("t1_op_rs1", op_rs1_data, 32'hA5A5_0001);
    check("t1_op_rs2", op_rs2_data, 32'd0);
    check("t1_op_tag", 32'(op_tag), 32'd1);

    // T2: issue-cycle writeback bypass
    cyc(); drive_req(4'd5, 4'd0, 4'd2); drive_wb(1'b1, 4'd5, 32'h0000_1234);
    cyc(); req_valid = 1'b0; drive_wb(1'b0, '0, '0);
    cyc(); #1;
    check("t2_op_valid", 32'(op_valid), 32'd1);
    check("t2_op_rs1", op_rs1_data, 32'h0000_1234);
    check("t2_op_tag", 32'(op_tag), 32'd2);

    // T3: S1-cycle writeback bypass
    cyc(); drive_req(4'd0, 4'd7, 4'd3);
    cyc(); req_valid = 1'b0; drive_wb(1'b1, 4'd7, 32'h0000_BEEF);
    cyc(); drive_wb(1'b0, '0, '0); #1;
    check("t3_op_valid", 32'(op_valid), 32'd1);
    check("t3_op_rs2", op_rs2_data, 32'h0000_BEEF);
    check("t3_op_tag", 32'(op_tag), 32'd3);

    // T4: backpressure, credit limit, head snoop, in-order drain
    cyc(); op_ready = 1'b0; drive_req(4'd9, 4'd0, 4'd4); #1;
    check("t4_a_ready", 32'(req_ready), 32'd1);
    cyc(); drive_req(4'd2, 4'd3, 4'd5); #1;
    check("t4_b_ready", 32'(req_ready), 32'd1);
    cyc(); drive_req(4'd0, 4'd9, 4'd6); #1;
    check("t4_c_blocked", 32'(req_ready), 32'd0);
    check("t4_c_rs2_read", 32'(rs2_read), 32'd0);
    check("t4_c_head_tag", 32'(op_tag), 32'd4);
    check("t4_c_head_rs1", op_rs1_data, 32'd0);
    cyc(); #1;
    check("t4_d_blocked", 32'(req_ready), 32'd0);
    drive_wb(1'b1, 4'd9, 32'h0000_0055);
    cyc(); drive_wb(1'b0, '0, '0); #1;
    check("t4_e_head_tag", 32'(op_tag), 32'd4);
    check("t4_e_snoop_rs1", op_rs1_data, 32'h0000_0055);
    op_ready = 1'b1; #1;
    check("t4_e_ready_on_pop", 32'(req_ready), 32'd1);
    check("t4_e_rs2_read", 32'(rs2_read), 32'd1);
    cyc(); req_valid = 1'b0; #1;
    check("t4_f_tag", 32'(op_tag), 32'd5);
    check("t4_f_rs1", op_rs1_data, 32'd0);
    check("t4_f_rs2", op_rs2_data, 32'hA5A5_0001);
    cyc(); #1;
    check("t4_g_valid", 32'(op_valid), 32'd1);
    check("t4_g_tag", 32'(op_tag), 32'd6);
    check("t4_g_rs2", op_rs2_data, 32'h0000_0055);
    cyc(); #1;
    check("t4_h_empty", 32'(op_valid), 32'd0);

    // T5: full throughput, 8 requests back to back
    for (int i = 1; i <= 8; i++) begin
      cyc(); drive_wb(1'b1, AW'(i), 32'h0000_1000 + 32'(i));
    end
    for (int c = 0; c < 11; c++) begin
      cyc();
      drive_wb(1'b0, '0, '0);
      if (c < 8) drive_req(AW'(c + 1), 4'd0, TAGW'(c));
      else req_valid = 1'b0;
      #1;
      if (c < 8) begin
        check("t5_req_ready", 32'(req_ready), 32'd1);
        exp_q.push_back({TAGW'(c), 32'h0000_1000 + 32'(c + 1)});
      end
      check("t5_op_valid", 32'(op_valid), (c >= 2 && c < 10) ? 32'd1 : 32'd0);
      if (op_valid) begin
        if (exp_q.size() == 0) begin
          check("t5_unexpected_op", 32'd1, 32'd0);
        end else begin
          exp_item = exp_q.pop_front();
          check("t5_op_tag", 32'(op_tag), 32'(exp_item[TAGW+XLEN-1:XLEN]));
          check("t5_op_rs1", op_rs1_data, exp_item[XLEN-1:0]);
        end
      end
    end
    check("t5_all_drained", 32'(exp_q.size()), 32'd0);

    // T6: x0 writes are dropped and x0 reads return zero
    cyc(); drive_wb(1'b1, 4'd0, 32'hFFFF_FFFF); #1;
    check("t6_rd_write_x0", 32'(rd_write), 32'd0);
    cyc(); drive_wb(1'b0, '0, '0); drive_req(4'd0, 4'd0, 4'd9); #1;
    check("t6_rs1_read_x0", 32'(rs1_read), 32'd0);
    cyc(); req_valid = 1'b0;
    cyc(); #1;
    check("t6_op_valid", 32'(op_valid), 32'd1);
    check("t6_op_rs1", op_rs1_data, 32'd0);
    check("t6_op_tag", 32'(op_tag), 32'd9);

    // T7: reset with one entry in S1 and one buffered
    cyc(); op_ready = 1'b0; drive_req(4'd1, 4'd2, 4'd10);
    cyc(); drive_req(4'd3, 4'd4, 4'd11);
    cyc(); req_valid = 1'b0; #1;
    check("t7_pre_rst_valid", 32'(op_valid), 32'd1);
    rst_n = 1'b0; #1;
    check("t7_rst_op_valid", 32'(op_valid), 32'd0);
    check("t7_rst_req_ready", 32'(req_ready), 32'd0);
    check("t7_rst_op_tag", 32'(op_tag), 32'd0);
    cyc(); rst_n = 1'b1; op_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc(); #1;
      check("t7_no_stale_op", 32'(op_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
